// File: rtl/hand_bank.sv
// Card storage for NUM_HANDS hands with running score and count per hand.
// Define HAND_NATURAL_EN to add the registered natural[] output.
module hand_bank #(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int HIDX_W         =
    (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int CNT_W          =
    $clog2(CARDS_PER_HAND + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    deal_valid,
  input  logic [HIDX_W-1:0]       deal_hand,
  input  logic [3:0]              deal_card,
  output logic                    deal_ready,
  input  logic [NUM_HANDS-1:0]    clr_hand,
  output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0]
                                  hand_cards,
  output logic [NUM_HANDS*CNT_W-1:0]
                                  hand_count,
  output logic [NUM_HANDS*4-1:0]  hand_score,
  output logic [NUM_HANDS-1:0]    hand_full
`ifdef HAND_NATURAL_EN
  ,
  output logic [NUM_HANDS-1:0]    natural
`endif
);

  logic [3:0] cards_q [NUM_HANDS][CARDS_PER_HAND];
  logic [3:0] cards_d [NUM_HANDS][CARDS_PER_HAND];
  logic [CNT_W-1:0] count_q [NUM_HANDS];
  logic [CNT_W-1:0] count_d [NUM_HANDS];
  logic [3:0] score_q [NUM_HANDS];
  logic [3:0] score_d [NUM_HANDS];

  logic [NUM_HANDS-1:0] sel;
  logic [NUM_HANDS-1:0] full;
  logic [3:0]           card_val;
  logic                 accept;
  logic [4:0]           sum;

`ifdef HAND_NATURAL_EN
  logic [NUM_HANDS-1:0] nat_q;
  logic [NUM_HANDS-1:0] nat_d;
  assign natural = nat_q;
`endif

  always_comb begin : decode
    sel  = '0;
    full = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      sel[h]  = deal_hand == HIDX_W'(h);
      full[h] = count_q[h] == CNT_W'(CARDS_PER_HAND);
    end
    deal_ready = |(sel & ~full & ~clr_hand);
    accept     = deal_valid & deal_ready;
    // Face cards and out-of-range codes score nothing
    if (deal_card >= 4'd1 && deal_card <= 4'd9)
      card_val = deal_card;
    else
      card_val = 4'd0;
  end

  assign hand_full = full;

  always_comb begin : next_state
    cards_d = cards_q;
    count_d = count_q;
    score_d = score_q;
    sum     = '0;
`ifdef HAND_NATURAL_EN
    nat_d   = nat_q;
`endif
    for (int h = 0; h < NUM_HANDS; h++) begin
      sum = {1'b0, score_q[h]} + {1'b0, card_val};
      if (sum >= 5'd10)
        sum = sum - 5'd10;
      if (clr_hand[h]) begin
        for (int s = 0; s < CARDS_PER_HAND; s++)
          cards_d[h][s] = '0;
        count_d[h] = '0;
        score_d[h] = '0;
`ifdef HAND_NATURAL_EN
        nat_d[h]   = 1'b0;
`endif
      end else if (accept && sel[h]) begin
        for (int s = 0; s < CARDS_PER_HAND; s++)
          if (count_q[h] == CNT_W'(s))
            cards_d[h][s] = deal_card;
        count_d[h] = count_q[h] + CNT_W'(1);
        score_d[h] = sum[3:0];
`ifdef HAND_NATURAL_EN
        if (count_q[h] == CNT_W'(1) &&
            sum[3:0] >= 4'd8)
          nat_d[h] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        for (int s = 0; s < CARDS_PER_HAND; s++)
          cards_q[h][s] <= '0;
        count_q[h] <= '0;
        score_q[h] <= '0;
      end
`ifdef HAND_NATURAL_EN
      nat_q <= '0;
`endif
    end else begin
      cards_q <= cards_d;
      count_q <= count_d;
      score_q <= score_d;
`ifdef HAND_NATURAL_EN
      nat_q   <= nat_d;
`endif
    end
  end

  // Unused slots stay zero, so they read blank
  always_comb begin : pack
    hand_cards = '0;
    hand_count = '0;
    hand_score = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      hand_count[h*CNT_W +: CNT_W] = count_q[h];
      hand_score[h*4 +: 4]         = score_q[h];
      for (int s = 0; s < CARDS_PER_HAND; s++)
        hand_cards[(h*CARDS_PER_HAND+s)*4 +: 4] =
          cards_q[h][s];
    end
  end

endmodule

// File: tb/tb_hand_bank.sv
// Bench for hand_bank: default 2x3 bank and a 3x5 bank,
// directed scenarios plus random traffic against a queue model.
module tb_hand_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, dv_a, rdy_a;
  logic [0:0]  dh_a;
  logic [3:0]  dc_a;
  logic [1:0]  clr_a;
  logic [23:0] cards_a;
  logic [3:0]  cnt_a;
  logic [7:0]  sc_a;
  logic [1:0]  full_a;

  logic        rst_b, dv_b, rdy_b;
  logic [1:0]  dh_b;
  logic [3:0]  dc_b;
  logic [2:0]  clr_b;
  logic [59:0] cards_b;
  logic [8:0]  cnt_b;
  logic [11:0] sc_b;
  logic [2:0]  full_b;

`ifdef HAND_NATURAL_EN
  logic [1:0]  nat_a;
  logic [2:0]  nat_b;
`endif

  hand_bank u_a (
    .clk        (clk),
    .rst        (rst_a),
    .deal_valid (dv_a),
    .deal_hand  (dh_a),
    .deal_card  (dc_a),
    .deal_ready (rdy_a),
    .clr_hand   (clr_a),
    .hand_cards (cards_a),
    .hand_count (cnt_a),
    .hand_score (sc_a),
    .hand_full  (full_a)
`ifdef HAND_NATURAL_EN
    ,
    .natural    (nat_a)
`endif
  );

  hand_bank #(
    .NUM_HANDS      (3),
    .CARDS_PER_HAND (5)
  ) u_b (
    .clk        (clk),
    .rst        (rst_b),
    .deal_valid (dv_b),
    .deal_hand  (dh_b),
    .deal_card  (dc_b),
    .deal_ready (rdy_b),
    .clr_hand   (clr_b),
    .hand_cards (cards_b),
    .hand_count (cnt_b),
    .hand_score (sc_b),
    .hand_full  (full_b)
`ifdef HAND_NATURAL_EN
    ,
    .natural    (nat_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: per bank, per hand, the list of cards held
  int mq [2][3][$];
  bit nat [2][3];

  function automatic int cval(int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic int mscore(int d, int h);
    int s = 0;
    for (int i = 0; i < mq[d][h].size(); i++)
      s += cval(mq[d][h][i]);
    return s % 10;
  endfunction

  function automatic logic [59:0] ecards(int d);
    int nh = d ? 3 : 2;
    int cph = d ? 5 : 3;
    logic [59:0] e = '0;
    for (int h = 0; h < nh; h++)
      for (int s = 0; s < mq[d][h].size(); s++)
        e |= 60'(mq[d][h][s] & 15) << ((h*cph+s)*4);
    return e;
  endfunction

  function automatic logic [8:0] ecount(int d);
    int nh = d ? 3 : 2;
    int cw = d ? 3 : 2;
    logic [8:0] e = '0;
    for (int h = 0; h < nh; h++)
      e |= 9'(mq[d][h].size()) << (h*cw);
    return e;
  endfunction

  function automatic logic [11:0] escore(int d);
    int nh = d ? 3 : 2;
    logic [11:0] e = '0;
    for (int h = 0; h < nh; h++)
      e |= 12'(mscore(d, h)) << (h*4);
    return e;
  endfunction

  function automatic logic [2:0] efull(int d);
    int nh = d ? 3 : 2;
    int cph = d ? 5 : 3;
    logic [2:0] e = '0;
    for (int h = 0; h < nh; h++)
      if (mq[d][h].size() == cph) e[h] = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] enat(int d);
    int nh = d ? 3 : 2;
    logic [2:0] e = '0;
    for (int h = 0; h < nh; h++)
      if (nat[d][h]) e[h] = 1'b1;
    return e;
  endfunction

  task automatic idle();
    rst_a = 0; dv_a = 0; dh_a = '0;
    dc_a = '0; clr_a = '0;
    rst_b = 0; dv_b = 0; dh_b = '0;
    dc_b = '0; clr_b = '0;
  endtask

  // Entered and left at a negedge; one clock per call
  task automatic step(
    input int d, input bit r, input bit v,
    input int h, input int c, input int clr,
    output bit er, output logic orr);
    int nh = d ? 3 : 2;
    int cph = d ? 5 : 3;
    if (d == 0) begin
      rst_a = r; dv_a = v; dh_a = 1'(h);
      dc_a = 4'(c); clr_a = 2'(clr);
    end else begin
      rst_b = r; dv_b = v; dh_b = 2'(h);
      dc_b = 4'(c); clr_b = 3'(clr);
    end
    er = 1'b0;
    if (h < nh)
      if (mq[d][h].size() < cph && !clr[h])
        er = 1'b1;
    #1;
    orr = d ? rdy_b : rdy_a;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        mq[d][k].delete();
        nat[d][k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < nh; k++)
        if (clr[k]) begin
          mq[d][k].delete();
          nat[d][k] = 1'b0;
        end
      if (v && er) begin
        mq[d][h].push_back(c);
        if (mq[d][h].size() == 2 &&
            mscore(d, h) >= 8)
          nat[d][h] = 1'b1;
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    bit er;
    logic orr;
    step(0, 1, 1, 0, 5, 0, er, orr);
    step(0, 1, 1, 0, 5, 0, er, orr);
    step(1, 1, 1, 0, 5, 0, er, orr);
    step(1, 1, 1, 0, 5, 0, er, orr);
    checks++;
    if (cards_a !== 24'h0) begin
      errors++;
      $display("FAIL rst_cards got %h want 0", cards_a);
    end
    checks++;
    if (cnt_a !== 4'h0 || sc_a !== 8'h0) begin
      errors++;
      $display("FAIL rst_cnt_sc got %h/%h want 0/0",
               cnt_a, sc_a);
    end
    checks++;
    if (full_a !== 2'b00) begin
      errors++;
      $display("FAIL rst_full got %b want 00", full_a);
    end
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", rdy_a);
    end
    checks++;
    if (cards_b !== 60'h0 || cnt_b !== 9'h0) begin
      errors++;
      $display("FAIL rst_b got %h/%h want 0/0",
               cards_b, cnt_b);
    end
  endtask

  task automatic test_fill_hand0();
    int cd [3] = '{13, 7, 5};
    int es [3] = '{0, 7, 2};
    bit er;
    logic orr;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, cd[i], 0, er, orr);
      checks++;
      if (orr !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d got %b want 1",
                 i, orr);
      end
      checks++;
      if (sc_a[3:0] !== 4'(es[i]) ||
          cnt_a[1:0] !== 2'(i+1)) begin
        errors++;
        $display("FAIL fill_sc%0d got %0d/%0d want %0d/%0d",
                 i, sc_a[3:0], cnt_a[1:0], es[i], i+1);
      end
    end
    checks++;
    if (full_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got %b want 1", full_a[0]);
    end
    step(0, 0, 1, 0, 4, 0, er, orr);
    checks++;
    if (orr !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse got %b want 0", orr);
    end
    checks++;
    if (cards_a[11:0] !== 12'h57D ||
        sc_a[3:0] !== 4'd2 || cnt_a[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL full_hold got %h/%0d/%0d want 57d/2/3",
               cards_a[11:0], sc_a[3:0], cnt_a[1:0]);
    end
  endtask

  task automatic test_hand1();
    bit er;
    logic orr;
    step(0, 0, 1, 1, 9, 0, er, orr);
    step(0, 0, 1, 1, 9, 0, er, orr);
    checks++;
    if (sc_a[7:4] !== 4'd8 ||
        cards_a[23:12] !== 12'h099) begin
      errors++;
      $display("FAIL h1_99 got %0d/%h want 8/099",
               sc_a[7:4], cards_a[23:12]);
    end
`ifdef HAND_NATURAL_EN
    checks++;
    if (nat_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL h1_nat got %b want 1", nat_a[1]);
    end
`endif
    step(0, 0, 1, 1, 1, 0, er, orr);
    checks++;
    if (sc_a[7:4] !== 4'd9 || full_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL h1_third got %0d/%b want 9/1",
               sc_a[7:4], full_a[1]);
    end
`ifdef HAND_NATURAL_EN
    checks++;
    if (nat_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL h1_nat3 got %b want 1", nat_a[1]);
    end
`endif
  endtask

  task automatic test_clear();
    bit er;
    logic orr;
    step(0, 0, 1, 0, 3, 1, er, orr);
    checks++;
    if (orr !== 1'b0) begin
      errors++;
      $display("FAIL clr_same_ready got %b want 0", orr);
    end
    checks++;
    if (cnt_a[1:0] !== 2'd0 || cards_a[11:0] !== 12'h0 ||
        sc_a[3:0] !== 4'd0 || cnt_a[3:2] !== 2'd3) begin
      errors++;
      $display("FAIL clr_same got %h/%h/%h want 0/0/3",
               cnt_a, cards_a[11:0], sc_a);
    end
    step(0, 0, 0, 0, 0, 2, er, orr);
    step(0, 0, 1, 0, 4, 0, er, orr);
    step(0, 0, 1, 1, 3, 1, er, orr);
    checks++;
    if (orr !== 1'b1) begin
      errors++;
      $display("FAIL clr_other_ready got %b want 1", orr);
    end
    checks++;
    if (cnt_a !== 4'b0100 || sc_a !== 8'h30 ||
        cards_a !== 24'h003000) begin
      errors++;
      $display("FAIL clr_other got %h/%h/%h want 4/30/003000",
               cnt_a, sc_a, cards_a);
    end
  endtask

  task automatic test_params();
    int es [5] = '{6, 2, 8, 4, 0};
    bit er;
    logic orr;
    step(1, 0, 1, 3, 6, 0, er, orr);
    checks++;
    if (orr !== 1'b0 || cnt_b !== 9'h0) begin
      errors++;
      $display("FAIL oob got %b/%h want 0/0", orr, cnt_b);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 2, 6, 0, er, orr);
      checks++;
      if (orr !== 1'b1 || sc_b[11:8] !== 4'(es[i])) begin
        errors++;
        $display("FAIL p_sc%0d got %b/%0d want 1/%0d",
                 i, orr, sc_b[11:8], es[i]);
      end
    end
    checks++;
    if (full_b !== 3'b100 || cnt_b[8:6] !== 3'd5) begin
      errors++;
      $display("FAIL p_full got %b/%0d want 100/5",
               full_b, cnt_b[8:6]);
    end
  endtask

  task automatic test_mid_reset();
    bit er;
    logic orr;
    step(0, 1, 0, 0, 0, 0, er, orr);
    step(0, 0, 1, 0, 2, 0, er, orr);
    step(0, 0, 1, 0, 3, 0, er, orr);
    checks++;
    if (cnt_a[1:0] !== 2'd2 || sc_a[3:0] !== 4'd5) begin
      errors++;
      $display("FAIL mr_pre got %0d/%0d want 2/5",
               cnt_a[1:0], sc_a[3:0]);
    end
    step(0, 1, 1, 0, 9, 0, er, orr);
    checks++;
    if (cards_a !== 24'h0 || cnt_a !== 4'h0 ||
        sc_a !== 8'h0 || full_a !== 2'b0) begin
      errors++;
      $display("FAIL mr_zero got %h/%h/%h want 0/0/0",
               cards_a, cnt_a, sc_a);
    end
    step(0, 0, 1, 0, 11, 0, er, orr);
    checks++;
    if (cards_a !== 24'h00000B || cnt_a !== 4'h1 ||
        sc_a !== 8'h0) begin
      errors++;
      $display("FAIL mr_slot0 got %h/%h/%h want b/1/0",
               cards_a, cnt_a, sc_a);
    end
  endtask

  task automatic test_random();
    bit er;
    logic orr;
    for (int d = 0; d < 2; d++) begin
      int nh = d ? 3 : 2;
      step(d, 1, 0, 0, 0, 0, er, orr);
      for (int n = 0; n < 250; n++) begin
        bit r = $urandom_range(0, 59) == 0;
        bit v = $urandom_range(0, 3) != 0;
        int h = $urandom_range(0, d ? 3 : 1);
        int c = $urandom_range(0, 15);
        int clr = 0;
        logic [59:0] oc;
        logic [8:0]  on;
        logic [11:0] os;
        logic [2:0]  of;
        if ($urandom_range(0, 7) == 0)
          clr = $urandom_range(0, (1 << nh) - 1);
        step(d, r, v, h, c, clr, er, orr);
        oc = d ? cards_b : 60'(cards_a);
        on = d ? cnt_b : 9'(cnt_a);
        os = d ? sc_b : 12'(sc_a);
        of = d ? full_b : 3'(full_a);
        checks++;
        if (orr !== er) begin
          errors++;
          $display("FAIL rnd_ready d%0d n%0d got %b want %b",
                   d, n, orr, er);
        end
        checks++;
        if (oc !== ecards(d)) begin
          errors++;
          $display("FAIL rnd_cards d%0d n%0d got %h want %h",
                   d, n, oc, ecards(d));
        end
        checks++;
        if (on !== ecount(d) || of !== efull(d)) begin
          errors++;
          $display("FAIL rnd_cnt d%0d n%0d got %h/%b want %h/%b",
                   d, n, on, of, ecount(d), efull(d));
        end
        checks++;
        if (os !== escore(d)) begin
          errors++;
          $display("FAIL rnd_score d%0d n%0d got %h want %h",
                   d, n, os, escore(d));
        end
`ifdef HAND_NATURAL_EN
        begin
          logic [2:0] onat;
          onat = d ? nat_b : 3'(nat_a);
          checks++;
          if (onat !== enat(d)) begin
            errors++;
            $display("FAIL rnd_nat d%0d n%0d got %b want %b",
                     d, n, onat, enat(d));
          end
        end
`endif
      end
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_fill_hand0();
    test_hand1();
    test_clear();
    test_params();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
